// File: rtl/fsbus_arbiter.sv
// Round-robin two-master controller for the shared flash/SSRAM bus.
// Sequences SSRAM pipelined accesses and flash strobe accesses; every output is a flop.
module fsbus_arbiter #(
  parameter int FLASH_WAIT = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [26:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [26:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] rdata,
  output logic [26:0] fs_addr,
  output logic [31:0] fs_dout,
  output logic        fs_oe,
  input  logic [31:0] fs_din,
  output logic        ssram0_ce_n,
  output logic        ssram1_ce_n,
  output logic        ssram_adsp_n,
  output logic        ssram_oe_n,
  output logic        ssram_we_n,
  output logic [3:0]  ssram_be_n,
  output logic        fl_ce_n,
  output logic        fl_oe_n,
  output logic        fl_we_n
);

  localparam int CW = (FLASH_WAIT > 1) ? $clog2(FLASH_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLASH_WAIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SS_ADDR   = 3'd1;
  localparam logic [2:0] S_SS_WAIT   = 3'd2;
  localparam logic [2:0] S_SS_DATA   = 3'd3;
  localparam logic [2:0] S_FL_SETUP  = 3'd4;
  localparam logic [2:0] S_FL_STROBE = 3'd5;
  localparam logic [2:0] S_FL_HOLD   = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [26:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [26:0]   fs_addr_q, fs_addr_d;
  logic [31:0]   fs_dout_q, fs_dout_d;
  logic          fs_oe_q, fs_oe_d;
  logic          ss0_ce_n_q, ss0_ce_n_d;
  logic          ss1_ce_n_q, ss1_ce_n_d;
  logic          adsp_n_q, adsp_n_d;
  logic          ss_oe_n_q, ss_oe_n_d;
  logic          ss_we_n_q, ss_we_n_d;
  logic [3:0]    ss_be_n_q, ss_be_n_d;
  logic          fl_ce_n_q, fl_ce_n_d;
  logic          fl_oe_n_q, fl_oe_n_d;
  logic          fl_we_n_q, fl_we_n_d;
  logic [1:0]    ack_q, ack_d;

  // Sequencing, arbitration and data capture.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // last_q holds the master granted last; a contested grant goes to the other one.
          gnt_d   = (m0_req && m1_req) ? ~last_q : m1_req;
          last_d  = gnt_d;
          we_d    = gnt_d ? m1_we    : m0_we;
          addr_d  = gnt_d ? m1_addr  : m0_addr;
          be_d    = gnt_d ? m1_be    : m0_be;
          wdata_d = gnt_d ? m1_wdata : m0_wdata;
          state_d = addr_d[26] ? S_FL_SETUP : S_SS_ADDR;
        end
      end
      S_SS_ADDR: state_d = we_q ? S_DONE : S_SS_WAIT;
      S_SS_WAIT: state_d = S_SS_DATA;
      S_SS_DATA: begin
        rdata_d = fs_din;
        state_d = S_DONE;
      end
      S_FL_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_FL_STROBE;
      end
      S_FL_STROBE: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = fs_din;
          state_d = S_FL_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FL_HOLD: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pins are decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    fs_addr_d  = fs_addr_q;
    fs_dout_d  = fs_dout_q;
    fs_oe_d    = 1'b0;
    ss0_ce_n_d = 1'b1;
    ss1_ce_n_d = 1'b1;
    adsp_n_d   = 1'b1;
    ss_oe_n_d  = 1'b1;
    ss_we_n_d  = 1'b1;
    ss_be_n_d  = 4'hf;
    fl_ce_n_d  = 1'b1;
    fl_oe_n_d  = 1'b1;
    fl_we_n_d  = 1'b1;
    ack_d      = 2'b00;
    case (state_d)
      S_SS_ADDR: begin
        fs_addr_d  = addr_d;
        ss0_ce_n_d = addr_d[21];
        ss1_ce_n_d = ~addr_d[21];
        adsp_n_d   = 1'b0;
        ss_be_n_d  = ~be_d;
        if (we_d) begin
          ss_we_n_d = 1'b0;
          fs_oe_d   = 1'b1;
          fs_dout_d = wdata_d;
        end else begin
          ss_oe_n_d = 1'b0;
        end
      end
      S_SS_WAIT, S_SS_DATA: ss_oe_n_d = 1'b0;
      S_FL_SETUP, S_FL_STROBE, S_FL_HOLD: begin
        fs_addr_d = addr_d;
        fl_ce_n_d = 1'b0;
        if (we_d) begin
          fs_oe_d   = 1'b1;
          fs_dout_d = wdata_d;
        end
        if (state_d == S_FL_STROBE) begin
          fl_we_n_d = ~we_d;
          fl_oe_n_d = we_d;
        end
      end
      S_DONE:  ack_d[gnt_d] = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fs_addr_q  <= '0;
      fs_dout_q  <= '0;
      fs_oe_q    <= 1'b0;
      ss0_ce_n_q <= 1'b1;
      ss1_ce_n_q <= 1'b1;
      adsp_n_q   <= 1'b1;
      ss_oe_n_q  <= 1'b1;
      ss_we_n_q  <= 1'b1;
      ss_be_n_q  <= 4'hf;
      fl_ce_n_q  <= 1'b1;
      fl_oe_n_q  <= 1'b1;
      fl_we_n_q  <= 1'b1;
      ack_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      fs_addr_q  <= fs_addr_d;
      fs_dout_q  <= fs_dout_d;
      fs_oe_q    <= fs_oe_d;
      ss0_ce_n_q <= ss0_ce_n_d;
      ss1_ce_n_q <= ss1_ce_n_d;
      adsp_n_q   <= adsp_n_d;
      ss_oe_n_q  <= ss_oe_n_d;
      ss_we_n_q  <= ss_we_n_d;
      ss_be_n_q  <= ss_be_n_d;
      fl_ce_n_q  <= fl_ce_n_d;
      fl_oe_n_q  <= fl_oe_n_d;
      fl_we_n_q  <= fl_we_n_d;
      ack_q      <= ack_d;
    end
  end

  assign m0_ack       = ack_q[0];
  assign m1_ack       = ack_q[1];
  assign rdata        = rdata_q;
  assign fs_addr      = fs_addr_q;
  assign fs_dout      = fs_dout_q;
  assign fs_oe        = fs_oe_q;
  assign ssram0_ce_n  = ss0_ce_n_q;
  assign ssram1_ce_n  = ss1_ce_n_q;
  assign ssram_adsp_n = adsp_n_q;
  assign ssram_oe_n   = ss_oe_n_q;
  assign ssram_we_n   = ss_we_n_q;
  assign ssram_be_n   = ss_be_n_q;
  assign fl_ce_n      = fl_ce_n_q;
  assign fl_oe_n      = fl_oe_n_q;
  assign fl_we_n      = fl_we_n_q;

endmodule

// File: tb/tb_fsbus_arbiter.sv
// Directed bench for fsbus_arbiter: transaction table plus per-cycle corner sequences.
// A second instance with FLASH_WAIT=1 checks the short flash timing.
module tb_fsbus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [26:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata;
  logic [31:0] fs_din;

  logic        m0_ack, m1_ack, fs_oe;
  logic [31:0] rdata, fs_dout;
  logic [26:0] fs_addr;
  logic        ssram0_ce_n, ssram1_ce_n, ssram_adsp_n, ssram_oe_n, ssram_we_n;
  logic [3:0]  ssram_be_n;
  logic        fl_ce_n, fl_oe_n, fl_we_n;

  logic        d1_m0_ack, d1_m1_ack, d1_fs_oe;
  logic [31:0] d1_rdata, d1_fs_dout;
  logic [26:0] d1_fs_addr;
  logic        d1_ss0_ce_n, d1_ss1_ce_n, d1_adsp_n, d1_ss_oe_n, d1_ss_we_n;
  logic [3:0]  d1_ss_be_n;
  logic        d1_fl_ce_n, d1_fl_oe_n, d1_fl_we_n;

  fsbus_arbiter #(.FLASH_WAIT(6)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .fs_addr(fs_addr), .fs_dout(fs_dout), .fs_oe(fs_oe), .fs_din(fs_din),
    .ssram0_ce_n(ssram0_ce_n), .ssram1_ce_n(ssram1_ce_n), .ssram_adsp_n(ssram_adsp_n),
    .ssram_oe_n(ssram_oe_n), .ssram_we_n(ssram_we_n), .ssram_be_n(ssram_be_n),
    .fl_ce_n(fl_ce_n), .fl_oe_n(fl_oe_n), .fl_we_n(fl_we_n)
  );

  fsbus_arbiter #(.FLASH_WAIT(1)) dut1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_ack(d1_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_ack(d1_m1_ack),
    .rdata(d1_rdata), .fs_addr(d1_fs_addr), .fs_dout(d1_fs_dout), .fs_oe(d1_fs_oe), .fs_din(fs_din),
    .ssram0_ce_n(d1_ss0_ce_n), .ssram1_ce_n(d1_ss1_ce_n), .ssram_adsp_n(d1_adsp_n),
    .ssram_oe_n(d1_ss_oe_n), .ssram_we_n(d1_ss_we_n), .ssram_be_n(d1_ss_be_n),
    .fl_ce_n(d1_fl_ce_n), .fl_oe_n(d1_fl_oe_n), .fl_we_n(d1_fl_we_n)
  );

  // Bus model: SSRAM data appears two clocks after adsp, flash data while fl_oe_n is low.
  logic [31:0] ss_val, fl_val;
  logic        adsp_d1, adsp_d2;
  always @(posedge clk) begin
    adsp_d1 <= ~ssram_adsp_n;
    adsp_d2 <= adsp_d1;
  end
  assign fs_din = adsp_d2 ? ss_val : (!fl_oe_n ? fl_val : 32'hBAD0BAD0);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        fs_oe, ss0_ce_n, ss1_ce_n, adsp_n, ss_oe_n, ss_we_n;
    logic [3:0]  be_n;
    logic        fl_ce_n, fl_oe_n, fl_we_n, ack0, ack1;
    logic [26:0] addr;
    logic [31:0] dout;
  } snap_t;
  snap_t trace [0:39];

  typedef struct {
    bit          m;
    bit          we;
    logic [26:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] din;
    int          lat;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs [6];

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Raises req at the start of cycle N, logs every cycle, drops req on ack. lat = -1 on timeout.
  task automatic run_txn(input bit m, input bit we, input logic [26:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output int lat, output bit other_ack);
    @(posedge clk);
    #1;
    if (m) begin
      m1_we = we; m1_addr = a; m1_be = be; m1_wdata = wd; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = a; m0_be = be; m0_wdata = wd; m0_req = 1'b1;
    end
    lat = -1;
    other_ack = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      trace[k] = '{fs_oe, ssram0_ce_n, ssram1_ce_n, ssram_adsp_n, ssram_oe_n, ssram_we_n, ssram_be_n,
                   fl_ce_n, fl_oe_n, fl_we_n, m0_ack, m1_ack, fs_addr, fs_dout};
      if (m ? m0_ack : m1_ack) other_ack = 1'b1;
      if (m ? m1_ack : m0_ack) begin
        lat = k;
        m0_req = 1'b0;
        m1_req = 1'b0;
        break;
      end
    end
  endtask

  int          lat;
  bit          oth;
  logic [9:0]  v_oe, v_low, v_ce;
  logic [3:0]  order_v;
  int          nacks;
  bit          both, any_ack;

  initial begin
    m0_we = 0; m1_we = 0; m0_addr = '0; m1_addr = '0; m0_be = '0; m1_be = '0;
    m0_wdata = '0; m1_wdata = '0; ss_val = '0; fl_val = '0;

    vecs[0] = '{1'b0, 1'b1, 27'h0000100, 4'b0011, 32'hDEADBEEF, 32'h0,        2, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 27'h0200040, 4'b1111, 32'h0,        32'h12345678, 4, 32'h12345678};
    vecs[2] = '{1'b0, 1'b0, 27'h4000010, 4'b1111, 32'h0,        32'hA5A55A5A, 9, 32'hA5A55A5A};
    vecs[3] = '{1'b1, 1'b1, 27'h0200080, 4'b1000, 32'h11112222, 32'h0,        2, 32'hA5A55A5A};
    vecs[4] = '{1'b0, 1'b1, 27'h4000020, 4'b1111, 32'h33334444, 32'h0,        9, 32'hA5A55A5A};
    vecs[5] = '{1'b1, 1'b0, 27'h0000200, 4'b0110, 32'h0,        32'h0F0F1234, 4, 32'h0F0F1234};

    do_reset();
    @(negedge clk);
    check("reset_strobes", {ssram0_ce_n, ssram1_ce_n, ssram_adsp_n, ssram_oe_n, ssram_we_n,
                            fl_ce_n, fl_oe_n, fl_we_n}, 64'hff);
    check("reset_be_n", ssram_be_n, 64'hf);
    check("reset_bus", {fs_oe, fs_addr, fs_dout}, 64'h0);
    check("reset_ack_rdata", {m0_ack, m1_ack, rdata}, 64'h0);

    foreach (vecs[i]) begin
      ss_val = vecs[i].din;
      fl_val = vecs[i].din;
      run_txn(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, lat, oth);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_other_ack", i), oth, 0);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
    end

    // SSRAM write cycle detail.
    do_reset();
    run_txn(0, 1, 27'h0000100, 4'b0011, 32'hDEADBEEF, lat, oth);
    check("ssw_ce", {trace[1].ss0_ce_n, trace[1].ss1_ce_n, trace[1].adsp_n}, 3'b010);
    check("ssw_we_oe", {trace[1].ss_we_n, trace[1].ss_oe_n, trace[1].fs_oe}, 3'b011);
    check("ssw_be_n", trace[1].be_n, 4'b1100);
    check("ssw_bus", {trace[1].addr, trace[1].dout}, {27'h0000100, 32'hDEADBEEF});
    check("ssw_done", {trace[2].ack0, trace[2].fs_oe, trace[2].ss0_ce_n}, 3'b101);

    // SSRAM read on chip 1: fs_oe must stay low.
    ss_val = 32'h12345678;
    run_txn(1, 0, 27'h0200040, 4'hf, 32'h0, lat, oth);
    check("ssr_ce", {trace[1].ss0_ce_n, trace[1].ss1_ce_n, trace[1].adsp_n, trace[1].ss_oe_n}, 4'b1000);
    check("ssr_wait", {trace[2].ss1_ce_n, trace[2].adsp_n, trace[2].ss_oe_n}, 3'b110);
    v_oe = '0;
    for (int k = 0; k < 10; k++) if (k <= lat) v_oe[k] = trace[k].fs_oe;
    check("ssr_fs_oe", v_oe, 0);
    check("ssr_ack", {lat, rdata}, {32'd4, 32'h12345678});

    // Flash read, FLASH_WAIT=6.
    fl_val = 32'hC0DE0001;
    run_txn(0, 0, 27'h4000000, 4'hf, 32'h0, lat, oth);
    v_oe = '0; v_low = '0;
    for (int k = 0; k < 10; k++) if (k <= lat) begin
      v_oe[k] = trace[k].fs_oe;
      v_low[k] = ~trace[k].fl_oe_n;
    end
    check("flr_oe_n_window", v_low, 10'b0011111100);
    check("flr_fs_oe", v_oe, 0);
    check("flr_ack", {lat, rdata}, {32'd9, 32'hC0DE0001});

    // Flash read on the FLASH_WAIT=1 instance.
    do_reset();
    fl_val = 32'h0BADF00D;
    @(posedge clk);
    #1;
    m0_we = 0; m0_addr = 27'h4000000; m0_be = 4'hf; m0_req = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d1_m0_ack) begin
        lat = k;
        m0_req = 1'b0;
        break;
      end
    end
    check("fw1_ack", {lat, d1_rdata}, {32'd4, 32'h0BADF00D});

    // Both masters requesting continuously from reset.
    do_reset();
    @(posedge clk);
    #1;
    m0_we = 1; m0_addr = 27'h0000010; m0_be = 4'hf; m0_wdata = 32'h1;
    m1_we = 1; m1_addr = 27'h0200010; m1_be = 4'hf; m1_wdata = 32'h2;
    m0_req = 1'b1; m1_req = 1'b1;
    nacks = 0; both = 0; order_v = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) both = 1;
      if (m0_ack || m1_ack) begin
        order_v[nacks] = m1_ack;
        nacks++;
        if (nacks == 4) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
          break;
        end
      end
    end
    check("arb_count", nacks, 4);
    check("arb_order", order_v, 4'b1010);
    check("arb_no_double_ack", both, 0);

    // Reset during FL_STROBE aborts without ack.
    do_reset();
    @(posedge clk);
    #1;
    m0_we = 0; m0_addr = 27'h4000040; m0_be = 4'hf; m0_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_in_strobe", {fl_ce_n, fl_oe_n}, 2'b00);
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    check("abort_outputs", {fl_ce_n, fl_oe_n, fs_oe, m0_ack, m1_ack}, 5'b11000);
    rst = 1'b0;
    any_ack = 0;
    repeat (12) begin
      @(negedge clk);
      if (m0_ack || m1_ack) any_ack = 1;
    end
    check("abort_no_ack", any_ack, 0);
    run_txn(0, 1, 27'h0000300, 4'hf, 32'h55AA55AA, lat, oth);
    check("abort_recover", lat, 2);

    // Flash write: data driven SETUP..HOLD, ce held one cycle past we.
    run_txn(0, 1, 27'h4000020, 4'hf, 32'hCAFEF00D, lat, oth);
    v_oe = '0; v_low = '0; v_ce = '0;
    for (int k = 0; k < 10; k++) if (k <= lat) begin
      v_oe[k] = trace[k].fs_oe;
      v_low[k] = ~trace[k].fl_we_n;
      v_ce[k] = ~trace[k].fl_ce_n;
    end
    check("flw_fs_oe", v_oe, 10'b0111111110);
    check("flw_we_window", v_low, 10'b0011111100);
    check("flw_ce_window", v_ce, 10'b0111111110);
    check("flw_hold_data", trace[8].dout, 32'hCAFEF00D);
    check("flw_latency", lat, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsbus_arbiter.md
# fsbus_arbiter

Two-requester controller for the shared flash/SSRAM bus (27-bit address, 32-bit data). Arbitrates round-robin between master 0 (CPU) and master 1 (DMA/video), decodes the target, and sequences the SSRAM pipelined single-cycle-address protocol or the slow asynchronous flash strobe protocol. The tristate `fs_databus` pad stays in the top level; this block provides separate in, out and output-enable signals.

## Interface
- `FLASH_WAIT`, 6: flash strobe width in clocks, minimum 1 (6 = 120 ns at 50 MHz).
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: synchronous, active-high reset.
- `m0_req`, `m1_req` in 1: request; held until ack.
- `m0_we`, `m1_we` in 1: 1 = write.
- `m0_addr`, `m1_addr` in 27: byte address; bit 26 selects flash (1) or SSRAM (0); for SSRAM, bit 21 selects chip 1.
- `m0_be`, `m1_be` in 4: byte enables, active high.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `rdata` out 32: read data, shared, valid with ack.
- `fs_addr` out 27: bus address.
- `fs_dout` out 32: bus write data.
- `fs_oe` out 1: drive enable for `fs_databus`.
- `fs_din` in 32: bus read data.
- `ssram0_ce_n`, `ssram1_ce_n`, `ssram_adsp_n`, `ssram_oe_n`, `ssram_we_n` out 1: SSRAM controls.
- `ssram_be_n` out 4: SSRAM byte enables, active low.
- `fl_ce_n`, `fl_oe_n`, `fl_we_n` out 1: flash controls.

## Operation
- All outputs are registered.
- Reset values: every `*_n` output 1, `ssram_be_n` 4'hf, `fs_addr` 0, `fs_dout` 0, `fs_oe` 0, both acks 0, `rdata` 0. The state is IDLE and the round-robin pointer favours m0.
- States: IDLE, SS_ADDR, SS_WAIT, SS_DATA, FL_SETUP, FL_STROBE, FL_HOLD, DONE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the master not granted last, then flip the pointer.
  - On grant, latch addr/we/be/wdata.
  - Next state is SS_ADDR if addr[26] is 0, otherwise FL_SETUP.
- SS_ADDR:
  - Drive `fs_addr`, the selected `ssram*_ce_n`=0, `ssram_adsp_n`=0, `ssram_be_n`=~be.
  - Write: `ssram_we_n`=0, `fs_oe`=1, `fs_dout`=wdata, then DONE.
  - Read: `ssram_oe_n`=0, then SS_WAIT.
- SS_WAIT: `ssram_oe_n`=0, ce and adsp deasserted, then SS_DATA.
- SS_DATA: `ssram_oe_n`=0; capture `fs_din` into `rdata` at the end of the cycle; then DONE.
- FL_SETUP:
  - Drive `fs_addr` and `fl_ce_n`=0.
  - On a write, also drive `fs_oe`=1 and `fs_dout`.
  - Load the wait counter with FLASH_WAIT-1; go to FL_STROBE.
- FL_STROBE:
  - `fl_oe_n`=0 (read) or `fl_we_n`=0 (write); decrement the counter.
  - When the counter reaches 0, capture `fs_din` on a read and go to FL_HOLD.
- FL_HOLD: strobes high; `fl_ce_n`, `fs_addr` and `fs_oe`/`fs_dout` held one cycle (write data hold); then DONE.
- DONE:
  - All chip selects, strobes and `fs_oe` are deasserted.
  - Pulse the granted master's ack; `rdata` holds the captured value.
  - Then IDLE.
- `fs_oe` is never 1 in the same cycle as `ssram_oe_n`=0 or `fl_oe_n`=0.
- Masters must drop req in the cycle after ack. A req still high in IDLE starts a new transaction.
- SSRAM writes do not update `rdata`.
- Reset asserted in any state aborts the transaction immediately: no ack, all outputs at reset values next cycle.

## Timing
- Req is sampled in IDLE on the edge ending cycle N. Acks are pulsed as follows:
  - SSRAM write: cycle N+2.
  - SSRAM read: cycle N+4, with data captured from `fs_din` during cycle N+3.
  - Flash access: cycle N+3+FLASH_WAIT.
- A new transaction can start at the earliest one cycle after DONE; the minimum back-to-back spacing is one IDLE cycle.
- A req arriving while the bus is busy waits. Worst-case wait for one master is a single transaction of the other master.

## Test plan
- Reset, then idle: all outputs at reset values. m0 SSRAM write addr 0x0000100, be 4'b0011, data 0xDEADBEEF:
  - one SS_ADDR cycle with `ssram0_ce_n`=0, `adsp_n`=0, `we_n`=0, `be_n`=4'b1100, `fs_oe`=1;
  - `m0_ack` at N+2.
- m1 SSRAM read addr 0x0200040, `fs_din` model returns 0x12345678 two clocks after adsp:
  - `ssram1_ce_n` asserted;
  - `m1_ack` at N+4 with `rdata`=0x12345678;
  - `fs_oe` stays 0 throughout.
- Flash read 0x4000000 with FLASH_WAIT=6: `fl_oe_n` low exactly 6 cycles, ack at N+9. Repeat with FLASH_WAIT=1: ack at N+4.
- Both reqs high continuously for 4 transactions from reset: grants m0, m1, m0, m1; no cycle has both acks high.
- Reset asserted during FL_STROBE: next cycle `fl_ce_n`=`fl_oe_n`=1, `fs_oe`=0, no ack; a following m0 request completes normally.
- Flash write: `fs_oe`=1 from FL_SETUP through FL_HOLD; `fl_we_n` low FLASH_WAIT cycles; `fl_ce_n` remains low one cycle after `fl_we_n` rises.
